bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It replaces the single-cycle unrolled converter with a generic, width-configurable unit. Results arrive through a start/done handshake with overflow detection and a leading-zero blanking mask. It sits between arithmetic datapaths and the seven-segment display drivers.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_cell.sv | 21 ++
 rtl/bin_to_bcd_seq.sv | 133 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Double-dabble correction: a digit of 5 or more would reach 10 or more
    // after doubling, so pre-add 3 to make the shift carry correctly.
    function automatic bcd_digit_t add3_adj(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the double-dabble chain: adjust, then shift left by one
// with carry_in entering bit 0 and the old bit 3 leaving as carry_out.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       carry_in,
    output bcd_digit_t next_digit,
    output logic       carry_out
);

    bcd_digit_t adj;

    // Adjust-and-shift for a single digit.
    always_comb begin
        adj        = add3_adj(digit);
        next_digit = {adj[2:0], carry_in};
        carry_out  = adj[3];
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one operand bit per clock, results
// delivered through a start/done handshake with overflow and blanking mask.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int                 CNT_W     = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(BIN_W - 1);
    // Reset / all-zero blanking: every digit blanked except the units digit.
    localparam logic [DIGITS-1:0]  BLANK_RST = ~(DIGITS'(1));

    state_t                state_q, state_d;
    logic [BIN_W-1:0]      opnd_q, opnd_d;
    logic [4*DIGITS-1:0]   work_q, work_d, work_shift;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sticky_q, sticky_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [DIGITS-1:0]     blank_q, blank_d, blank_calc;
    logic [DIGITS:0]       carry;

    // Operand MSB feeds the least significant digit; the top carry is the
    // bit that no longer fits in DIGITS decimal digits.
    assign carry[0] = opnd_q[BIN_W-1];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_cell
            bcd_digit_cell u_cell (
                .digit      (work_q[4*gi +: 4]),
                .carry_in   (carry[gi]),
                .next_digit (work_shift[4*gi +: 4]),
                .carry_out  (carry[gi+1])
            );
        end
    endgenerate

    // Leading-zero mask of the post-shift digits, scanned from the top down.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        blank_calc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above    = zero_above & (work_shift[4*i +: 4] == 4'd0);
            blank_calc[i] = zero_above;
        end
        blank_calc[0] = 1'b0;
    end

    // Next-state and datapath control; the final shift also loads the outputs
    // so that they are valid in the DONE cycle.
    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        blank_d  = blank_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d   = bin_in;
                    work_d   = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                opnd_d   = opnd_q << 1;
                work_d   = work_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                sticky_d = sticky_q | carry[DIGITS];
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DONE;
                    bcd_d   = work_shift;
                    ovf_d   = sticky_q | carry[DIGITS];
                    blank_d = blank_calc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opnd_q   <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            blank_q  <= BLANK_RST;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            blank_q  <= blank_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
    assign blank    = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench: default 13-bit/4-digit unit plus a 3-digit unit for
// the overflow cases.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [12:0] bin_a, bin_b;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [15:0] bcd_a;
    logic [11:0] bcd_b;
    logic [3:0]  blank_a;
    logic [2:0]  blank_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(13), .DIGITS(4)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .bin_in   (bin_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd_out  (bcd_a),
        .overflow (ovf_a),
        .blank    (blank_a)
    );

    bin_to_bcd_seq #(.BIN_W(13), .DIGITS(3)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .bin_in   (bin_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd_out  (bcd_b),
        .overflow (ovf_b),
        .blank    (blank_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion on unit A (sel=0) or B (sel=1); returns the number of
    // edges from the start edge (counted as 1) until done is seen high.
    task automatic convert(input bit sel, input logic [12:0] v, output int lat);
        @(negedge clk);
        if (sel) begin bin_b = v; start_b = 1'b1; end
        else     begin bin_a = v; start_a = 1'b1; end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        while (!(sel ? done_b : done_a) && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("conv unit=%0d bin=%0d lat=%0d bcd_a=%h ovf_a=%b blank_a=%b bcd_b=%h ovf_b=%b",
                 sel, v, lat, bcd_a, ovf_a, blank_a, bcd_b, ovf_b);
    endtask

    initial begin
        int lat, cyc, gap, seen;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",    busy_a,  0);
        check_eq("rst_done",    done_a,  0);
        check_eq("rst_bcd",     bcd_a,   0);
        check_eq("rst_ovf",     ovf_a,   0);
        check_eq("rst_blank",   blank_a, 4'b1110);
        check_eq("rst_blank_b", blank_b, 3'b110);
        rst = 1'b0;

        // Basic conversions on the default unit
        convert(1'b0, 13'd4321, lat);
        check_eq("lat_4321",   lat,     14);
        check_eq("bcd_4321",   bcd_a,   16'h4321);
        check_eq("blank_4321", blank_a, 4'b0000);
        check_eq("ovf_4321",   ovf_a,   0);
        check_eq("busy_done",  busy_a,  1);

        convert(1'b0, 13'd0, lat);
        check_eq("bcd_0",   bcd_a,   16'h0000);
        check_eq("blank_0", blank_a, 4'b1110);

        convert(1'b0, 13'd7, lat);
        check_eq("bcd_7",   bcd_a,   16'h0007);
        check_eq("blank_7", blank_a, 4'b1110);

        convert(1'b0, 13'd8191, lat);
        check_eq("bcd_8191", bcd_a, 16'h8191);
        check_eq("ovf_8191", ovf_a, 0);

        // Overflow on the 3-digit unit, then sticky flag cleared
        convert(1'b1, 13'd8191, lat);
        check_eq("b_bcd_8191", bcd_b, 12'h191);
        check_eq("b_ovf_8191", ovf_b, 1);
        convert(1'b1, 13'd999, lat);
        check_eq("b_bcd_999",   bcd_b,   12'h999);
        check_eq("b_ovf_999",   ovf_b,   0);
        check_eq("b_blank_999", blank_b, 3'b000);

        // start pulsed during SHIFT, then held high through done
        @(negedge clk); bin_a = 13'd1234; start_a = 1'b1;
        @(posedge clk); cyc = 1;
        @(negedge clk); start_a = 1'b0;
        @(posedge clk); cyc = 2;
        @(negedge clk); start_a = 1'b1; bin_a = 13'd8000;
        @(posedge clk); cyc = 3;
        @(negedge clk); start_a = 1'b0;
        @(posedge clk); cyc = 4;
        @(negedge clk); start_a = 1'b1; bin_a = 13'd5678;
        while (!done_a && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
        end
        $display("conv unit=0 bin=1234 lat=%0d bcd_a=%h (start noise)", cyc, bcd_a);
        check_eq("noise_lat", cyc,   14);
        check_eq("noise_bcd", bcd_a, 16'h1234);
        @(posedge clk); gap = 1;
        @(negedge clk);
        check_eq("done_one_cycle", done_a, 0);
        while (!done_a && gap < 40) begin
            @(posedge clk); gap++;
            @(negedge clk);
            if (busy_a) start_a = 1'b0;
        end
        start_a = 1'b0;
        $display("conv unit=0 bin=5678 gap=%0d bcd_a=%h (back-to-back)", gap, bcd_a);
        check_eq("b2b_gap", gap,   15);
        check_eq("b2b_bcd", bcd_a, 16'h5678);

        // Reset mid-conversion
        @(negedge clk); bin_a = 13'd1234; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        $display("abort unit=0 bin=1234 busy=%b bcd_a=%h blank=%b", busy_a, bcd_a, blank_a);
        check_eq("abort_busy",  busy_a,  0);
        check_eq("abort_done",  done_a,  0);
        check_eq("abort_bcd",   bcd_a,   0);
        check_eq("abort_ovf",   ovf_a,   0);
        check_eq("abort_blank", blank_a, 4'b1110);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) seen++;
        end
        check_eq("abort_no_done", seen, 0);

        convert(1'b0, 13'd56, lat);
        check_eq("bcd_56",   bcd_a,   16'h0056);
        check_eq("blank_56", blank_a, 4'b1100);
        check_eq("lat_56",   lat,     14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
